// File: rtl/decoder.sv
// RV32I-subset decode stage: instruction word -> ALU op, immediate format, write enables, register indices.
// Define DECODER_COMB_OUT_EN to drop the output registers (zero latency, clk/rst_n unused).
module decoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         instruction,
  output logic [2:0]                    alu_op,
  output logic [2:0]                    imm_op,
  output logic                          mem_write,
  output logic                          reg_write,
  output logic [$clog2(DATA_WIDTH)-1:0] rs1,
  output logic [$clog2(DATA_WIDTH)-1:0] rs2,
  output logic [$clog2(DATA_WIDTH)-1:0] rd
);

  localparam int RW = $clog2(DATA_WIDTH);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NONE = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  logic [6:0]    opc;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic [RW-1:0] rd_f, rs1_f, rs2_f;

  assign opc   = instruction[6:0];
  assign rd_f  = instruction[11:7];
  assign f3    = instruction[14:12];
  assign rs1_f = instruction[19:15];
  assign rs2_f = instruction[24:20];
  assign f7    = instruction[31:25];

  // Shared OP / OP-IMM funct3 mapping; shifts-right and SLTU fall to invalid.
  function automatic logic [2:0] f3_to_alu(input logic [2:0] f);
    case (f)
      3'b000:  f3_to_alu = 3'b000;
      3'b111:  f3_to_alu = 3'b010;
      3'b110:  f3_to_alu = 3'b011;
      3'b100:  f3_to_alu = 3'b100;
      3'b010:  f3_to_alu = 3'b101;
      3'b001:  f3_to_alu = 3'b110;
      default: f3_to_alu = ALU_NONE;
    endcase
  endfunction

  logic [2:0]    alu_d, imm_d;
  logic          mw_d, rw_d;
  logic [RW-1:0] rs1_d, rs2_d, rd_d;
  logic [2:0]    op_alu;

  always_comb begin
    alu_d  = ALU_NONE;
    imm_d  = IMM_NONE;
    mw_d   = 1'b0;
    rw_d   = 1'b0;
    rs1_d  = '0;
    rs2_d  = '0;
    rd_d   = '0;
    op_alu = ALU_NONE;
    // X/Z in the selector matches no item, so it lands on the invalid defaults.
    case (opc)
      OPC_LOAD: begin
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            alu_d = ALU_ADD; imm_d = IMM_I; rw_d = 1'b1; rs1_d = rs1_f; rd_d = rd_f;
          end
          default: ;
        endcase
      end
      OPC_STORE: begin
        case (f3)
          3'b000, 3'b001, 3'b010: begin
            alu_d = ALU_ADD; imm_d = IMM_S; mw_d = 1'b1; rs1_d = rs1_f; rs2_d = rs2_f;
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        if (f7 == 7'b0000000) op_alu = f3_to_alu(f3);
        else if (f7 == 7'b0100000 && f3 == 3'b000) op_alu = ALU_SUB;
        if (op_alu != ALU_NONE) begin
          alu_d = op_alu; rw_d = 1'b1; rs1_d = rs1_f; rs2_d = rs2_f; rd_d = rd_f;
        end
      end
      OPC_OPIMM: begin
        op_alu = f3_to_alu(f3);
        if (f3 == 3'b001 && f7 != 7'b0000000) op_alu = ALU_NONE;
        if (op_alu != ALU_NONE) begin
          alu_d = op_alu; imm_d = IMM_I; rw_d = 1'b1; rs1_d = rs1_f; rd_d = rd_f;
        end
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000, 3'b001: begin
            alu_d = ALU_SUB; imm_d = IMM_B; rs1_d = rs1_f; rs2_d = rs2_f;
          end
          default: ;
        endcase
      end
      OPC_LUI: begin
        alu_d = ALU_ADD; imm_d = IMM_U; rw_d = 1'b1; rd_d = rd_f;
      end
      OPC_JAL: begin
        alu_d = ALU_ADD; imm_d = IMM_J; rw_d = 1'b1; rd_d = rd_f;
      end
      default: ;
    endcase
  end

`ifdef DECODER_COMB_OUT_EN
  assign alu_op    = alu_d;
  assign imm_op    = imm_d;
  assign mem_write = mw_d;
  assign reg_write = rw_d;
  assign rs1       = rs1_d;
  assign rs2       = rs2_d;
  assign rd        = rd_d;
`else
  logic [2:0]    alu_q, imm_q;
  logic          mw_q, rw_q;
  logic [RW-1:0] rs1_q, rs2_q, rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q <= ALU_NONE;
      imm_q <= IMM_NONE;
      mw_q  <= 1'b0;
      rw_q  <= 1'b0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
    end else begin
      alu_q <= alu_d;
      imm_q <= imm_d;
      mw_q  <= mw_d;
      rw_q  <= rw_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rd_q  <= rd_d;
    end
  end

  assign alu_op    = alu_q;
  assign imm_op    = imm_q;
  assign mem_write = mw_q;
  assign reg_write = rw_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
`endif

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder (default registered build): hand-encoded instructions with hand-derived bundles.
module tb_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [2:0]  alu_op, imm_op;
  logic        mem_write, reg_write;
  logic [4:0]  rs1, rs2, rd;

  int ncmp = 0;
  int nerr = 0;

  localparam logic [22:0] INV = {3'b111, 3'b111, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0};

  decoder #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .alu_op(alu_op), .imm_op(imm_op), .mem_write(mem_write), .reg_write(reg_write),
    .rs1(rs1), .rs2(rs2), .rd(rd)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] bnd(input logic [2:0] a, input logic [2:0] i, input logic mw,
                                      input logic rw, input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [4:0] d);
    return {a, i, mw, rw, s1, s2, d};
  endfunction

  task automatic chk(input string tag, input logic [22:0] exp);
    logic [22:0] obs;
    obs = {alu_op, imm_op, mem_write, reg_write, rs1, rs2, rd};
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed alu=%b imm=%b mw=%b rw=%b rs1=%0d rs2=%0d rd=%0d, expected %h (got %h)",
             tag, alu_op, imm_op, mem_write, reg_write, rs1, rs2, rd, exp, obs);
    end
  endtask

  task automatic step(input logic [31:0] instr, input string tag, input logic [22:0] exp);
    instruction = instr;
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  logic [31:0] LW, SW, SUB, BEQ, LUI, JAL, SRA, ADD, XORI, SLLI, SLLI_BAD, SLT, LD_BAD, OPC_BAD, BLT, ADDI0;

  initial begin
    LW       = {12'd0, 5'd21, 3'b010, 5'd21, 7'b0000011};
    SW       = {7'd0, 5'd5, 5'd2, 3'b010, 5'b01000, 7'b0100011};
    SUB      = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    BEQ      = {7'd0, 5'd2, 5'd1, 3'b000, 5'b01000, 7'b1100011};
    LUI      = {20'h12345, 5'd7, 7'b0110111};
    JAL      = {20'h00100, 5'd1, 7'b1101111};
    SRA      = {7'b0100000, 5'd3, 5'd2, 3'b101, 5'd1, 7'b0110011};
    ADD      = {7'd0, 5'd6, 5'd5, 3'b000, 5'd4, 7'b0110011};
    XORI     = {12'hFFF, 5'd10, 3'b100, 5'd9, 7'b0010011};
    SLLI     = {7'd0, 5'd3, 5'd2, 3'b001, 5'd1, 7'b0010011};
    SLLI_BAD = {7'b0100000, 5'd3, 5'd2, 3'b001, 5'd1, 7'b0010011};
    SLT      = {7'd0, 5'd3, 5'd2, 3'b010, 5'd1, 7'b0110011};
    LD_BAD   = {12'd0, 5'd21, 3'b011, 5'd21, 7'b0000011};
    OPC_BAD  = {12'd0, 5'd21, 3'b010, 5'd21, 7'b0000010};
    BLT      = {7'd0, 5'd2, 5'd1, 3'b100, 5'b01000, 7'b1100011};
    ADDI0    = 32'h0000_0013;

    rst_n = 1'b0;
    instruction = LW;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", INV);
    rst_n = 1'b1;

    step(LW,   "lw",   bnd(3'b000, 3'b000, 1'b0, 1'b1, 5'd21, 5'd0, 5'd21));
    step(32'hFFFF_FFFF, "all_ones", INV);
    step(SW,   "sw",   bnd(3'b000, 3'b001, 1'b1, 1'b0, 5'd2, 5'd5, 5'd0));
    step(SUB,  "sub",  bnd(3'b001, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3));
    step(BEQ,  "beq",  bnd(3'b001, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0));
    step(LUI,  "lui",  bnd(3'b000, 3'b011, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7));
    step(JAL,  "jal",  bnd(3'b000, 3'b100, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1));
    step(SRA,  "sra",  INV);
    step(ADD,  "add",  bnd(3'b000, 3'b111, 1'b0, 1'b1, 5'd5, 5'd6, 5'd4));
    step(XORI, "xori", bnd(3'b100, 3'b000, 1'b0, 1'b1, 5'd10, 5'd0, 5'd9));
    step(SLLI, "slli", bnd(3'b110, 3'b000, 1'b0, 1'b1, 5'd2, 5'd0, 5'd1));
    step(SLLI_BAD, "slli_f7", INV);
    step(SLT,  "slt",  bnd(3'b101, 3'b111, 1'b0, 1'b1, 5'd2, 5'd3, 5'd1));
    step(LD_BAD,  "load_f3", INV);
    step(OPC_BAD, "opc_lsb", INV);
    step(BLT,  "blt",  INV);
    step(ADDI0, "addi_x0", bnd(3'b000, 3'b000, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0));
    step('x,   "x_in", INV);

    // Latency: output holds the previous edge's decode until the next edge.
    step(LW, "b2b_lw", bnd(3'b000, 3'b000, 1'b0, 1'b1, 5'd21, 5'd0, 5'd21));
    instruction = 32'hFFFF_FFFF;
    #2;
    chk("b2b_hold", bnd(3'b000, 3'b000, 1'b0, 1'b1, 5'd21, 5'd0, 5'd21));
    @(posedge clk);
    #1;
    chk("b2b_ones", INV);

    // Asynchronous reset mid-stream.
    step(SW, "pre_rst", bnd(3'b000, 3'b001, 1'b1, 1'b0, 5'd2, 5'd5, 5'd0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", INV);
    @(posedge clk);
    #1;
    chk("rst_held", INV);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst", bnd(3'b000, 3'b001, 1'b1, 1'b0, 5'd2, 5'd5, 5'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
